// File: rtl/demux_rr_scheduler_pkg.sv
// Shared constants, FSM encoding and select decode for the 1:8 round-robin demux sequencer.
package demux_rr_scheduler_pkg;
    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        return NUM_CH'(1) << s;
    endfunction
endpackage

// File: rtl/demux_rr_scheduler_rr_next_sel.sv
// Cyclic search of an 8-bit enable mask starting at cur (inclusive) or just after cur (exclusive).
// Combinational; the exclusive search ends on cur itself, so a lone enabled channel selects itself.
module demux_rr_scheduler_rr_next_sel
    import demux_rr_scheduler_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              inclusive,
    output logic [SEL_W-1:0]  nxt,
    output logic              found
);
    logic [SEL_W-1:0] base;

    always_comb begin
        base  = inclusive ? cur : cur + SEL_W'(1);
        nxt   = cur;
        found = 1'b0;
        // Walk backwards so the nearest enabled channel is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[base + SEL_W'(i)]) begin
                nxt   = base + SEL_W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin sequencer for a 1:8 demux: DWELL words per enabled channel, 1-cycle registered output,
// in_ready drops on channel backpressure or dwell exhaustion; DEMUX_CNT_EN adds the xfer_cnt drain counter.
module demux_rr_scheduler
    import demux_rr_scheduler_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DWELL  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] ch_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0] out_valid,
    output logic [SEL_W-1:0]  sel,
    output logic              busy
`ifdef DEMUX_CNT_EN
    ,
    output logic [15:0]       xfer_cnt
`endif
);
    localparam logic [7:0] DWELL_C = 8'(DWELL);

    state_t           state;
    logic [7:0]       dwell_cnt;
    logic             buf_full;
    logic             cur_en;
    logic             cur_rdy;
    logic             buf_free;
    logic             accept;
    logic             drain;
    logic             switch_now;
    logic [SEL_W-1:0] nxt_sel;
    logic             nxt_found;

    assign cur_en   = ch_en[sel];
    assign cur_rdy  = ch_ready[sel];
    // The buffer counts as free when it is already empty or is being drained this cycle.
    assign buf_free = !buf_full || cur_rdy;
    assign in_ready = (state == XFER) && cur_en && (dwell_cnt < DWELL_C) && buf_free;
    assign accept   = in_valid && in_ready;
    assign drain    = buf_full && cur_rdy;
    assign switch_now = (state == XFER) && ((dwell_cnt == DWELL_C) || !cur_en) && buf_free;

    assign busy      = (state == XFER);
    assign out_valid = buf_full ? sel_onehot(sel) : '0;

    demux_rr_scheduler_rr_next_sel u_next_sel (
        .mask      (ch_en),
        .cur       (sel),
        .inclusive (state == IDLE),
        .nxt       (nxt_sel),
        .found     (nxt_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            dwell_cnt <= '0;
            buf_full  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (accept) begin
                out_data <= in_data;
                buf_full <= 1'b1;
            end else if (drain) begin
                buf_full <= 1'b0;
            end

            if (state == IDLE) begin
                if (nxt_found) begin
                    sel       <= nxt_sel;
                    dwell_cnt <= '0;
                    state     <= XFER;
                end
            end else begin
                // A switch never coincides with an accept: in_ready is low whenever switch_now is high.
                if (switch_now) begin
                    dwell_cnt <= '0;
                    if (nxt_found) begin
                        sel <= nxt_sel;
                    end else begin
                        state <= IDLE;
                    end
                end else if (accept) begin
                    dwell_cnt <= dwell_cnt + 8'd1;
                end
            end
        end
    end

`ifdef DEMUX_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (drain) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed bench for demux_rr_scheduler: reset, rotation, sparse mask, backpressure, disable, empty mask.
module tb_demux_rr_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] ch_en;
    logic [7:0] ch_ready;
    logic [7:0] out_data;
    logic [7:0] out_valid;
    logic [2:0] sel;
    logic       busy;
`ifdef DEMUX_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    always #5 clk = ~clk;

    demux_rr_scheduler #(.DATA_W(8), .DWELL(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ch_en     (ch_en),
        .ch_ready  (ch_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .sel       (sel),
        .busy      (busy)
`ifdef DEMUX_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    int         d_ch[$];
    int         d_dat[$];
    int         bubbles;
    int         onehot_err;
    logic [7:0] seen;
    int         sp_ch[4] = '{0, 2, 7, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        ch_en    = 8'h00;
        ch_ready = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Streams an incrementing word sequence and logs every drain as (channel, data).
    task automatic stream(input int n_drains, input int budget);
        logic acc;
        d_ch.delete();
        d_dat.delete();
        bubbles    = 0;
        onehot_err = 0;
        seen       = 8'h00;
        for (int c = 0; c < budget && d_ch.size() < n_drains; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if ((out_valid & ch_ready) != 8'h00) begin
                d_ch.push_back(int'(sel));
                d_dat.push_back(int'(out_data));
            end
            seen = seen | out_valid;
            if (busy && !in_ready) bubbles++;
            if (out_valid != 8'h00 && out_valid != (8'h01 << sel)) onehot_err++;
            tick();
            if (acc) in_data = in_data + 8'd1;
        end
        if (d_ch.size() < n_drains) check("stream_timeout", d_ch.size(), n_drains);
    endtask

    initial begin
        int n;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_out_valid", out_valid, 8'h00);
        check("rst_sel", sel, 3'd0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_data", out_data, 8'h00);

        // Reset mid-transfer with a word buffered on channel 3
        do_reset();
        ch_en = 8'h08; in_valid = 1'b1; in_data = 8'h77;
        tick();
        tick();
        @(negedge clk);
        check("mid_pre_sel", sel, 3'd3);
        check("mid_pre_valid", out_valid, 8'h08);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 8'h00);
        check("mid_rst_sel", sel, 3'd0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_data", out_data, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0; ch_en = 8'hFF;
        tick();
        @(negedge clk);
        check("mid_repick_sel", sel, 3'd0);
        check("mid_repick_busy", busy, 1'b1);

        // Basic rotation, all channels enabled and ready
        do_reset();
        ch_en = 8'hFF; ch_ready = 8'hFF; in_valid = 1'b1;
        stream(33, 200);
        in_valid = 1'b0;
        n = (d_ch.size() < 33) ? d_ch.size() : 33;
        for (int i = 0; i < n; i++) begin
            check($sformatf("rot_ch[%0d]", i), d_ch[i], (i / 4) % 8);
            check($sformatf("rot_dat[%0d]", i), d_dat[i], i);
        end
        check("rot_bubbles", bubbles, 8);
        check("rot_onehot", onehot_err, 0);
`ifdef DEMUX_CNT_EN
        check("rot_xfer_cnt", xfer_cnt, 16'd33);
`endif

        // Sparse mask 1000_0101
        do_reset();
        ch_en = 8'b1000_0101; ch_ready = 8'hFF; in_valid = 1'b1;
        stream(16, 200);
        in_valid = 1'b0;
        n = (d_ch.size() < 16) ? d_ch.size() : 16;
        for (int i = 0; i < n; i++) begin
            check($sformatf("sp_ch[%0d]", i), d_ch[i], sp_ch[i / 4]);
            check($sformatf("sp_dat[%0d]", i), d_dat[i], i);
        end
        check("sp_seen", seen, 8'h85);

        // Only one channel enabled: sel stays put across dwell boundaries
        do_reset();
        ch_en = 8'h10; ch_ready = 8'hFF; in_valid = 1'b1;
        stream(9, 100);
        in_valid = 1'b0;
        n = (d_ch.size() < 9) ? d_ch.size() : 9;
        for (int i = 0; i < n; i++) begin
            check($sformatf("solo_ch[%0d]", i), d_ch[i], 4);
            check($sformatf("solo_dat[%0d]", i), d_dat[i], i);
        end

        // Backpressure: buffer full, channel not ready for 10 cycles
        do_reset();
        ch_en = 8'hFF; ch_ready = 8'h00; in_valid = 1'b1; in_data = 8'hA5;
        tick();
        tick();
        in_data = 8'h3C;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_data !== 8'hA5 || sel !== 3'd0 || out_valid !== 8'h01) n++;
            tick();
        end
        check("bp_stable", n, 0);
        check("bp_data", out_data, 8'hA5);
        check("bp_in_ready", in_ready, 1'b0);
        ch_ready = 8'hFF;
        @(negedge clk);
        check("bp_release_rdy", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_data", out_data, 8'h3C);
        check("bp_next_valid", out_valid, 8'h01);

        // Disable the active channel with its second word buffered
        do_reset();
        ch_en = 8'hFF; ch_ready = 8'h00; in_valid = 1'b1; in_data = 8'hD0;
        tick();
        tick();
        ch_ready = 8'hFF; in_data = 8'hD1;
        tick();
        ch_ready = 8'h00; ch_en = 8'hFE; in_data = 8'hD2;
        @(negedge clk);
        check("dis_in_ready", in_ready, 1'b0);
        check("dis_held_valid", out_valid, 8'h01);
        check("dis_held_data", out_data, 8'hD1);
        tick();
        @(negedge clk);
        check("dis_held_sel", sel, 3'd0);
        ch_ready = 8'hFF;
        tick();
        @(negedge clk);
        check("dis_new_sel", sel, 3'd1);
        check("dis_new_valid", out_valid, 8'h00);
        check("dis_new_rdy", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("dis_d2_valid", out_valid, 8'h02);
        check("dis_d2_data", out_data, 8'hD2);

        // Empty mask, then a single enable, then empty again
        do_reset();
        ch_en = 8'h00; ch_ready = 8'hFF; in_valid = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("empty_busy", busy, 1'b0);
        check("empty_in_ready", in_ready, 1'b0);
        check("empty_sel", sel, 3'd0);
        ch_en = 8'h10;
        tick();
        check("en4_sel", sel, 3'd4);
        check("en4_busy", busy, 1'b1);
        ch_en = 8'h00; in_valid = 1'b0;
        @(negedge clk);
        check("off_in_ready", in_ready, 1'b0);
        tick();
        check("off_busy", busy, 1'b0);
        check("off_sel", sel, 3'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
